downsample_controller: RTL and testbench
========================================

# downsample_controller

Sequencer that reduces the 1-bit drawing canvas to the classifier's input image. It scans the source bitmap in BLK×BLK blocks and assembles each block into a parallel pixel vector for the external n-pixel averaging unit (n = BLK²). It writes each averaged, signed-range result into the destination image memory in raster order. It sits between the canvas framebuffer and the network input buffer and is started once per frame.

## Interface
- `IMG_DIM`, 28: output image side (pixels); output has IMG_DIM² pixels.
- `BLK`, 4: block side; source side SRC_DIM = IMG_DIM·BLK; averager width n = BLK². BLK is a power of 2, ≥ 2.
- `RES`, 8: averager output resolution (bits).
- `clk` in 1: single clock, all logic on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state and outputs.
- `start` in 1: one-cycle request to process a frame; honoured only in IDLE.
- `busy` out 1: high from the cycle after start is accepted until done.
- `done` out 1: one-cycle pulse after the last destination write.
- `src_rd_en` out 1: source read strobe.
- `src_addr` out clog2(SRC_DIM²/BLK): source word address = row·IMG_DIM + block_col; each word is BLK horizontally adjacent pixels.
- `src_rd_data` in BLK: source word, valid exactly 1 cycle after `src_rd_en`; bit j = column block_col·BLK + j.
- `avg_pixels` out BLK²: pixel vector to averager; row k of block occupies bits [k·BLK +: BLK].
- `avg_out` in RES: averager result, registered, valid 1 cycle after `avg_pixels` is sampled.
- `dst_we` out 1: destination write strobe.
- `dst_addr` out clog2(IMG_DIM²): destination address = by·IMG_DIM + bx.
- `dst_data` out RES: value written; equals `avg_out` while `dst_we`.

## Operation
- States: IDLE, RD, CAP, AVG, WR, FIN.
- IDLE: `start` → RD with by = bx = k = 0; `busy` rises.
- RD (BLK cycles, k = 0..BLK-1): `src_rd_en`=1, `src_addr` = (by·BLK+k)·IMG_DIM + bx. Data returned for row k-1 is written into `avg_pixels` row k-1 (from k = 1).
- CAP (1 cycle): no read; row BLK-1 captured into `avg_pixels`.
- AVG (1 cycle): `avg_pixels` stable; averager samples it at end of cycle.
- WR (1 cycle): `dst_we`=1, `dst_addr` = by·IMG_DIM+bx, `dst_data` = `avg_out`. Then bx+1; on bx = IMG_DIM-1 wrap bx→0, by+1. Last block (by = bx = IMG_DIM-1) → FIN, else → RD with k = 0.
- FIN (1 cycle): `done`=1, `busy`=0 → IDLE.
- `avg_pixels` is not cleared between blocks; every row is overwritten before AVG.
- `start` in any state other than IDLE is ignored (no queueing); `start` in FIN is also ignored.
- Reset in any state: IDLE, counters 0, `avg_pixels` 0, all strobes low immediately (asynchronous); no partial `done`.
- Reset values: `busy`, `done`, `src_rd_en`, `dst_we` = 0; `src_addr`, `dst_addr`, `dst_data`, `avg_pixels` = 0.

## Timing
- Per block: BLK + 3 cycles (BLK reads, CAP, AVG, WR).
- Frame: start accepted at edge E0; first `src_rd_en` in cycle after E0; `done` in cycle IMG_DIM²·(BLK+3)+1 after E0 (defaults: 5489).
- Source read latency fixed at 1; averager latency fixed at 1; no stalls supported.
- Counters by, bx: clog2(IMG_DIM) bits; k: clog2(BLK)+1 bits; no overflow on wrap.

## Configuration
- `DOWNSAMPLE_ABORT_EN`: when defined, adds input `abort` (1 bit). `abort` high in any non-IDLE state forces IDLE on the next edge: `busy`→0, strobes low, no `done`, no further writes; already-written pixels remain. `abort` has priority over `start` in the same cycle; `abort` in IDLE has no effect.
- Without the macro: no `abort` port; a frame always runs to completion unless `reset`.

## Test plan
- All-zero source, start → 784 writes, each `dst_data`=0, addresses 0..783 in order, `done` exactly once at cycle 5489.
- All-ones source (averager model RES=8, n=16) → every write = 127.
- Block (by=2, bx=5) with 8 ones, rest zero → write at `dst_addr`=61 is 63; all others 0; verify `avg_pixels` row layout during AVG.
- `start` pulsed mid-frame and in FIN → ignored; exactly one `done`, no extra writes.
- `reset` asserted asynchronously during RD of block 100 → outputs clear same cycle; new `start` restarts at `dst_addr`=0.
- With `DOWNSAMPLE_ABORT_EN`, `abort` during WR of block 10 and `start` same cycle → IDLE next edge, no `done`, no writes after address 10.

Source files
------------

// File: rtl/downsample_controller.sv
// Block-scan sequencer: reads the SRC_DIM x SRC_DIM canvas in BLK x BLK blocks, feeds the external
// averager and writes its results in raster order. Define DOWNSAMPLE_ABORT_EN to add the abort input.
module downsample_controller #(
    parameter  int IMG_DIM = 28,
    parameter  int BLK     = 4,
    parameter  int RES     = 8,
    localparam int SRC_DIM = IMG_DIM * BLK,
    localparam int SA_W    = $clog2(SRC_DIM * SRC_DIM / BLK),
    localparam int DA_W    = $clog2(IMG_DIM * IMG_DIM),
    localparam int C_W     = $clog2(IMG_DIM),
    localparam int K_W     = $clog2(BLK) + 1
) (
    input  logic               clk,
    input  logic               reset,
`ifdef DOWNSAMPLE_ABORT_EN
    input  logic               abort,
`endif
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               src_rd_en,
    output logic [SA_W-1:0]    src_addr,
    input  logic [BLK-1:0]     src_rd_data,
    output logic [BLK*BLK-1:0] avg_pixels,
    input  logic [RES-1:0]     avg_out,
    output logic               dst_we,
    output logic [DA_W-1:0]    dst_addr,
    output logic [RES-1:0]     dst_data
);

    // state | meaning
    // IDLE  | waiting for start
    // RD    | issuing source read for block row k
    // CAP   | capturing last block row, no read
    // AVG   | pixel vector stable for the averager
    // WR    | writing averager result to destination
    // FIN   | one-cycle done pulse
    typedef enum logic [2:0] {S_IDLE, S_RD, S_CAP, S_AVG, S_WR, S_FIN} state_t;

    state_t         state;
    logic [C_W-1:0] by, bx;
    logic [K_W-1:0] k;

    logic           abort_req;
    logic           last_col, last_blk;
    logic [C_W-1:0] nbx, nby;
    logic [SA_W-1:0] blk_base;
    logic           cap_en;
    logic [K_W-1:0] cap_row;

`ifdef DOWNSAMPLE_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    assign last_col = (bx == C_W'(IMG_DIM - 1));
    assign last_blk = last_col && (by == C_W'(IMG_DIM - 1));
    assign nbx      = last_col ? '0 : bx + C_W'(1);
    assign nby      = last_col ? by + C_W'(1) : by;
    assign blk_base = SA_W'(nby) * SA_W'(BLK * IMG_DIM) + SA_W'(nbx);

    // read data trails the strobe by one cycle, so row k-1 lands while row k is requested
    assign cap_en  = ((state == S_RD) && (k != '0)) || (state == S_CAP);
    assign cap_row = (state == S_CAP) ? K_W'(BLK - 1) : k - K_W'(1);

    assign dst_data = dst_we ? avg_out : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            by         <= '0;
            bx         <= '0;
            k          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            src_rd_en  <= 1'b0;
            src_addr   <= '0;
            avg_pixels <= '0;
            dst_we     <= 1'b0;
            dst_addr   <= '0;
        end else if (abort_req && (state != S_IDLE)) begin
            state     <= S_IDLE;
            by        <= '0;
            bx        <= '0;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            src_rd_en <= 1'b0;
            dst_we    <= 1'b0;
        end else begin
            if (cap_en) begin
                avg_pixels[int'(cap_row) * BLK +: BLK] <= src_rd_data;
            end
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state     <= S_RD;
                        by        <= '0;
                        bx        <= '0;
                        k         <= '0;
                        busy      <= 1'b1;
                        src_rd_en <= 1'b1;
                        src_addr  <= '0;
                    end
                end
                S_RD: begin
                    if (k == K_W'(BLK - 1)) begin
                        state     <= S_CAP;
                        src_rd_en <= 1'b0;
                    end else begin
                        k        <= k + K_W'(1);
                        src_addr <= src_addr + SA_W'(IMG_DIM);
                    end
                end
                S_CAP: begin
                    state <= S_AVG;
                end
                S_AVG: begin
                    state    <= S_WR;
                    dst_we   <= 1'b1;
                    dst_addr <= DA_W'(by) * DA_W'(IMG_DIM) + DA_W'(bx);
                end
                S_WR: begin
                    dst_we <= 1'b0;
                    if (last_blk) begin
                        state <= S_FIN;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        by    <= '0;
                        bx    <= '0;
                    end else begin
                        state     <= S_RD;
                        bx        <= nbx;
                        by        <= nby;
                        k         <= '0;
                        src_rd_en <= 1'b1;
                        src_addr  <= blk_base;
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_downsample_controller.sv
// Randomized bench for downsample_controller: source memory and averager models plus a block-level
// reference image; checks write order, values, pixel layout, done timing, reset and (optionally) abort.
module tb_downsample_controller;
    localparam int IMG_DIM   = 28;
    localparam int BLK       = 4;
    localparam int RES       = 8;
    localparam int SRC_DIM   = IMG_DIM * BLK;
    localparam int N         = BLK * BLK;
    localparam int NPIX      = IMG_DIM * IMG_DIM;
    localparam int SA_W      = $clog2(SRC_DIM * SRC_DIM / BLK);
    localparam int DA_W      = $clog2(NPIX);
    localparam int FRAME_CYC = NPIX * (BLK + 3) + 1;
    localparam int AVG_MAX   = (2 ** (RES - 1)) - 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic            busy, done, src_rd_en, dst_we;
    logic [SA_W-1:0] src_addr;
    logic [BLK-1:0]  src_rd_data = '0;
    logic [N-1:0]    avg_pixels;
    logic [RES-1:0]  avg_out = '0;
    logic [DA_W-1:0] dst_addr;
    logic [RES-1:0]  dst_data;
`ifdef DOWNSAMPLE_ABORT_EN
    logic            abort;
`endif

    always #5 clk = ~clk;

    downsample_controller #(.IMG_DIM(IMG_DIM), .BLK(BLK), .RES(RES)) dut (
        .clk(clk),
        .reset(reset),
`ifdef DOWNSAMPLE_ABORT_EN
        .abort(abort),
`endif
        .start(start),
        .busy(busy),
        .done(done),
        .src_rd_en(src_rd_en),
        .src_addr(src_addr),
        .src_rd_data(src_rd_data),
        .avg_pixels(avg_pixels),
        .avg_out(avg_out),
        .dst_we(dst_we),
        .dst_addr(dst_addr),
        .dst_data(dst_data)
    );

    logic [SRC_DIM-1:0] src_row [SRC_DIM];
    int exp_img [NPIX];
    int tests = 0;
    int fails = 0;
    int wr_count = 0;
    int done_count = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // external units: 1-cycle source memory and 1-cycle registered averager
    always @(posedge clk) begin
        if (src_rd_en)
            src_rd_data <= src_row[int'(src_addr) / IMG_DIM][(int'(src_addr) % IMG_DIM) * BLK +: BLK];
        avg_out <= RES'(($countones(avg_pixels) * AVG_MAX) / N);
    end

    function automatic logic [N-1:0] exp_vec(input int a);
        logic [N-1:0] v;
        int r0, c0;
        r0 = (a / IMG_DIM) * BLK;
        c0 = (a % IMG_DIM) * BLK;
        for (int kk = 0; kk < BLK; kk++)
            for (int j = 0; j < BLK; j++)
                v[kk * BLK + j] = src_row[r0 + kk][c0 + j];
        return v;
    endfunction

    task automatic build_ref();
        for (int a = 0; a < NPIX; a++) begin
            int cnt;
            cnt = 0;
            for (int r = 0; r < BLK; r++)
                for (int c = 0; c < BLK; c++)
                    cnt += int'(src_row[(a / IMG_DIM) * BLK + r][(a % IMG_DIM) * BLK + c]);
            exp_img[a] = (cnt * AVG_MAX) / N;
        end
    endtask

    task automatic fill(input int mode);
        int dens;
        logic [N-1:0] v;
        dens = $urandom_range(10, 90);
        for (int r = 0; r < SRC_DIM; r++)
            for (int c = 0; c < SRC_DIM; c++)
                case (mode)
                    1:       src_row[r][c] = 1'b1;
                    3:       src_row[r][c] = ($urandom_range(0, 99) < dens);
                    default: src_row[r][c] = 1'b0;
                endcase
        if (mode == 2) begin
            v = {(N / 2){2'b01}};
            for (int t = 0; t < 1000; t++) begin
                logic [N-1:0] cand;
                cand = N'($urandom);
                if ($countones(cand) == N / 2) begin
                    v = cand;
                    break;
                end
            end
            for (int kk = 0; kk < BLK; kk++)
                for (int j = 0; j < BLK; j++)
                    src_row[2 * BLK + kk][5 * BLK + j] = v[kk * BLK + j];
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (done) done_count++;
            if (dst_we) begin
                check_val("wr_addr", 64'(dst_addr), 64'(wr_count));
                if (wr_count < NPIX) begin
                    check_val("wr_data", 64'(dst_data), 64'(exp_img[wr_count]));
                    check_val("avg_pixels", 64'(avg_pixels), 64'(exp_vec(wr_count)));
                end
                wr_count++;
            end
        end
    end

    task automatic check_idle_outputs(input string name);
        check_val({name, "/busy"}, 64'(busy), 0);
        check_val({name, "/done"}, 64'(done), 0);
        check_val({name, "/src_rd_en"}, 64'(src_rd_en), 0);
        check_val({name, "/dst_we"}, 64'(dst_we), 0);
        check_val({name, "/src_addr"}, 64'(src_addr), 0);
        check_val({name, "/dst_addr"}, 64'(dst_addr), 0);
        check_val({name, "/dst_data"}, 64'(dst_data), 0);
        check_val({name, "/avg_pixels"}, 64'(avg_pixels), 0);
    endtask

    // mid_cyc: extra start pulse; rst_cyc: async reset point; abort_cyc: abort+start point (0 = unused)
    task automatic run_frame(input string name, input int mid_cyc, input int rst_cyc, input int abort_cyc);
        int done_cyc;
        done_cyc = -1;
        build_ref();
        wr_count = 0;
        done_count = 0;
        @(negedge clk);
        start = 1'b1;
        for (int c = 1; c <= FRAME_CYC + 20; c++) begin
            @(negedge clk);
            start = (c == mid_cyc) || (c == FRAME_CYC) || (c == abort_cyc);
`ifdef DOWNSAMPLE_ABORT_EN
            abort = (c == abort_cyc);
`endif
            if (c == 1) begin
                check_val({name, "/busy_c1"}, 64'(busy), 1);
                check_val({name, "/rd_en_c1"}, 64'(src_rd_en), 1);
                check_val({name, "/src_addr_c1"}, 64'(src_addr), 0);
            end
            if (done && done_cyc < 0) done_cyc = c;
            if (c == rst_cyc) begin
                check_val({name, "/busy_pre_rst"}, 64'(busy), 1);
                #2 reset = 1'b1;
                #1 check_idle_outputs({name, "/async_rst"});
                @(negedge clk);
                reset = 1'b0;
                start = 1'b0;
                return;
            end
            if (abort_cyc > 0 && c == abort_cyc + 1) begin
                check_val({name, "/busy_post_abort"}, 64'(busy), 0);
                check_val({name, "/rd_en_post_abort"}, 64'(src_rd_en), 0);
            end
            if (abort_cyc > 0 && c == abort_cyc + 30) break;
        end
        start = 1'b0;
`ifdef DOWNSAMPLE_ABORT_EN
        abort = 1'b0;
`endif
        if (abort_cyc > 0) begin
            check_val({name, "/writes"}, 64'(wr_count), 11);
            check_val({name, "/done_count"}, 64'(done_count), 0);
        end else begin
            check_val({name, "/done_cyc"}, 64'(done_cyc), 64'(FRAME_CYC));
            check_val({name, "/done_count"}, 64'(done_count), 1);
            check_val({name, "/writes"}, 64'(wr_count), 64'(NPIX));
        end
        check_val({name, "/busy_end"}, 64'(busy), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
`ifdef DOWNSAMPLE_ABORT_EN
        abort = 1'b0;
`endif
        for (int r = 0; r < SRC_DIM; r++) src_row[r] = '0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_busy", 64'(busy), 0);

        fill(0);
        run_frame("zero", 0, 0, 0);
        fill(1);
        run_frame("ones", 0, 0, 0);
        fill(2);
        run_frame("blk61", 0, 0, 0);
        check_val("blk61_ref", 64'(exp_img[61]), 63);
        fill(3);
        run_frame("mid_start", 2500, 0, 0);
        fill(3);
        run_frame("rst_blk100", 0, 100 * (BLK + 3) + 2, 0);
        fill(3);
        run_frame("restart", 0, 0, 0);
`ifdef DOWNSAMPLE_ABORT_EN
        fill(3);
        run_frame("abort_blk10", 0, 0, 11 * (BLK + 3));
`endif
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
